// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// ---------------
// Control FSM for a multicycle RV32I-style datapath. It walks each instruction
// through FETCH -> DECODE -> EXEC [-> MEM [-> WB]] and drives the datapath
// enables. Outputs are decoded from the current state, the opcode and the acks,
// so ir_we_o can fire in the same cycle as imem_ack_i.
//
// Parameters
//   TIMEOUT      maximum cycles to wait in FETCH or MEM for an acknowledge
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset; forces every output low at once
//   instr_i      instruction register contents (valid from DECODE onward)
//   br_taken_i   branch comparator result, used in EXEC
//   imem_ack_i   instruction memory acknowledge (only seen in FETCH)
//   dmem_ack_i   data memory acknowledge (only seen in MEM)
//   imem_req_o   instruction fetch request
//   dmem_req_o   data memory request
//   dmem_we_o    data memory write enable (stores)
//   ir_we_o      instruction register write enable
//   pc_we_o      PC write enable
//   rf_we_o      register file write enable
//   pc_sel_o     next-PC select: 0=pc+4, 1=pc+imm, 2=ALU (JALR)
//   imm_sel_o    immediate format: 0=none, 1=I, 2=S, 3=B, 4=J
//   wb_sel_o     write-back source: 0=ALU, 1=memory, 2=pc+4
//   retire_o     one pulse per completed instruction (same as pc_we_o)
//   illegal_o    sticky: trapped on an unknown opcode
//   timeout_o    sticky: trapped waiting for a memory acknowledge
module multicycle_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] instr_i,
   input  logic        br_taken_i,
   input  logic        imem_ack_i,
   input  logic        dmem_ack_i,
   output logic        imem_req_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic        ir_we_o,
   output logic        pc_we_o,
   output logic        rf_we_o,
   output logic [1:0]  pc_sel_o,
   output logic [2:0]  imm_sel_o,
   output logic [1:0]  wb_sel_o,
   output logic        retire_o,
   output logic        illegal_o,
   output logic        timeout_o
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          illegal_q, illegal_d;
   logic          timeout_q, timeout_d;

   // Raw (pre-reset-gating) output decode
   logic       imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, rf_we_c;
   logic [1:0] pc_sel_c, wb_sel_c;
   logic [2:0] imm_sel_c;

   logic [6:0] opcode;
   assign opcode = instr_i[6:0];

   // Only the opcode field steers control; the rest belongs to the datapath.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr_i[31:7];

   function automatic logic [2:0] imm_of(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_IALU, OP_JALR: imm_of = 3'd1;
         OP_STORE:                  imm_of = 3'd2;
         OP_BR:                     imm_of = 3'd3;
         OP_JAL:                    imm_of = 3'd4;
         default:                   imm_of = 3'd0;
      endcase
   endfunction

   function automatic logic is_legal(input logic [6:0] op);
      is_legal = (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) ||
                 (op == OP_STORE) || (op == OP_BR) || (op == OP_JAL) ||
                 (op == OP_JALR);
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      illegal_d  = illegal_q;
      timeout_d  = timeout_q;
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
      ir_we_c    = 1'b0;
      pc_we_c    = 1'b0;
      rf_we_c    = 1'b0;
      pc_sel_c   = 2'd0;
      wb_sel_c   = 2'd0;
      imm_sel_c  = 3'd0;

      // Immediate format is held for the whole instruction once decoded.
      if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB})
         imm_sel_c = imm_of(opcode);

      case (state_q)
         S_FETCH: begin
            imem_req_c = 1'b1;
            // Ack wins over the timeout in the last allowed cycle.
            if (imem_ack_i) begin
               ir_we_c = 1'b1;
               state_d = S_DECODE;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DECODE: begin
            if (is_legal(opcode)) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end

         S_EXEC: begin
            state_d = S_FETCH;
            cnt_d   = '0;
            case (opcode)
               OP_R, OP_IALU: begin
                  rf_we_c = 1'b1;
                  pc_we_c = 1'b1;
               end
               OP_BR: begin
                  pc_we_c  = 1'b1;
                  pc_sel_c = br_taken_i ? 2'd1 : 2'd0;
               end
               OP_JAL: begin
                  rf_we_c  = 1'b1;
                  wb_sel_c = 2'd2;
                  pc_we_c  = 1'b1;
                  pc_sel_c = 2'd1;
               end
               OP_JALR: begin
                  rf_we_c  = 1'b1;
                  wb_sel_c = 2'd2;
                  pc_we_c  = 1'b1;
                  pc_sel_c = 2'd2;
               end
               OP_LOAD, OP_STORE: begin
                  state_d = S_MEM;
               end
               default: begin
                  // Opcode changed under us after DECODE: treat as illegal.
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end

         S_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = (opcode == OP_STORE);
            if (dmem_ack_i) begin
               if (opcode == OP_STORE) begin
                  pc_we_c = 1'b1;
                  state_d = S_FETCH;
                  cnt_d   = '0;
               end else begin
                  state_d = S_WB;
               end
            end else if (cnt_q == CNT_MAX) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_WB: begin
            rf_we_c  = 1'b1;
            wb_sel_c = 2'd1;
            pc_we_c  = 1'b1;
            state_d  = S_FETCH;
            cnt_d    = '0;
         end

         S_TRAP: begin
            state_d = S_TRAP;
         end

         default: begin
            state_d = S_TRAP;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   // The state sits in FETCH during reset, so the decoded outputs are masked
   // by rst_i to keep everything low for as long as reset is held.
   assign imem_req_o = imem_req_c & ~rst_i;
   assign dmem_req_o = dmem_req_c & ~rst_i;
   assign dmem_we_o  = dmem_we_c  & ~rst_i;
   assign ir_we_o    = ir_we_c    & ~rst_i;
   assign pc_we_o    = pc_we_c    & ~rst_i;
   assign rf_we_o    = rf_we_c    & ~rst_i;
   assign pc_sel_o   = rst_i ? 2'd0 : pc_sel_c;
   assign imm_sel_o  = rst_i ? 3'd0 : imm_sel_c;
   assign wb_sel_o   = rst_i ? 2'd0 : wb_sel_c;
   assign retire_o   = pc_we_o;
   assign illegal_o  = illegal_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// ------------------
// Builds the expected per-cycle output trace of each instruction from the
// instruction-level rules (fetch wait, decode, execute, memory wait, write
// back, trap), queues it together with the acks to drive, then plays the
// queue against the controller and compares every cycle.
module tb_multicycle_ctrl;

   localparam int TMO = 16;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] instr_i = '0;
   logic        br_taken_i = 1'b0;
   logic        imem_ack_i = 1'b0;
   logic        dmem_ack_i = 1'b0;
   logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, rf_we_o;
   logic [1:0]  pc_sel_o, wb_sel_o;
   logic [2:0]  imm_sel_o;
   logic        retire_o, illegal_o, timeout_o;

   multicycle_ctrl #(.TIMEOUT(TMO)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .instr_i    (instr_i),
      .br_taken_i (br_taken_i),
      .imem_ack_i (imem_ack_i),
      .dmem_ack_i (dmem_ack_i),
      .imem_req_o (imem_req_o),
      .dmem_req_o (dmem_req_o),
      .dmem_we_o  (dmem_we_o),
      .ir_we_o    (ir_we_o),
      .pc_we_o    (pc_we_o),
      .rf_we_o    (rf_we_o),
      .pc_sel_o   (pc_sel_o),
      .imm_sel_o  (imm_sel_o),
      .wb_sel_o   (wb_sel_o),
      .retire_o   (retire_o),
      .illegal_o  (illegal_o),
      .timeout_o  (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   // Observed outputs packed in the same order as mk() below.
   logic [15:0] outs;
   assign outs = {imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, rf_we_o,
                  pc_sel_o, imm_sel_o, wb_sel_o, retire_o, illegal_o, timeout_o};

   typedef struct {
      logic [31:0] ins;
      bit          ia;
      bit          da;
      bit          bt;
      logic [15:0] exp;
      string       tag;
   } cyc_t;

   cyc_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%04h exp=%04h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected output vector; retire always mirrors the PC write.
   function automatic logic [15:0] mk(input bit ireq, input bit dreq, input bit dwe,
                                      input bit irwe, input bit pcwe, input bit rfwe,
                                      input bit [1:0] pcs, input bit [2:0] imm,
                                      input bit [1:0] wbs, input bit ill, input bit tmo);
      return {ireq, dreq, dwe, irwe, pcwe, rfwe, pcs, imm, wbs, pcwe, ill, tmo};
   endfunction

   function automatic bit [2:0] imm_of(input bit [6:0] op);
      case (op)
         7'b0000011, 7'b0010011, 7'b1100111: return 3'd1;
         7'b0100011:                         return 3'd2;
         7'b1100011:                         return 3'd3;
         7'b1101111:                         return 3'd4;
         default:                            return 3'd0;
      endcase
   endfunction

   function automatic bit legal(input bit [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                        7'b1100011, 7'b1101111, 7'b1100111};
   endfunction

   function automatic bit rnd();
      return bit'($urandom_range(0, 1));
   endfunction

   task automatic add(input logic [31:0] ins, input bit ia, input bit da, input bit bt,
                      input logic [15:0] e, input string tag);
      cyc_t c;
      c.ins = ins; c.ia = ia; c.da = da; c.bt = bt; c.exp = e; c.tag = tag;
      q.push_back(c);
   endtask

   // Queue the cycles of one instruction. kind: 0 retired, 1 illegal trap,
   // 2 timeout trap. Acks outside their own phase are random noise.
   task automatic build(input logic [31:0] ins, input int fw, input int mw, input bit bt,
                        output int kind);
      bit [6:0] op;
      bit [2:0] imm;
      bit       st;
      op   = ins[6:0];
      imm  = imm_of(op);
      st   = (op == 7'b0100011);
      kind = 0;
      if (fw >= TMO) begin
         for (int i = 0; i < TMO; i++)
            add(ins, 1'b0, rnd(), rnd(), mk(1,0,0,0,0,0,0,0,0,0,0), "fetch_wait");
         kind = 2;
         return;
      end
      for (int i = 0; i < fw; i++)
         add(ins, 1'b0, rnd(), rnd(), mk(1,0,0,0,0,0,0,0,0,0,0), "fetch_wait");
      add(ins, 1'b1, rnd(), rnd(), mk(1,0,0,1,0,0,0,0,0,0,0), "fetch_ack");
      add(ins, rnd(), rnd(), rnd(), mk(0,0,0,0,0,0,0,imm,0,0,0), "decode");
      if (!legal(op)) begin
         kind = 1;
         return;
      end
      case (op)
         7'b0110011, 7'b0010011:
            add(ins, rnd(), rnd(), bt, mk(0,0,0,0,1,1,0,imm,0,0,0), "exec_alu");
         7'b1100011:
            add(ins, rnd(), rnd(), bt, mk(0,0,0,0,1,0,bt ? 2'd1 : 2'd0,imm,0,0,0), "exec_br");
         7'b1101111:
            add(ins, rnd(), rnd(), bt, mk(0,0,0,0,1,1,1,imm,2,0,0), "exec_jal");
         7'b1100111:
            add(ins, rnd(), rnd(), bt, mk(0,0,0,0,1,1,2,imm,2,0,0), "exec_jalr");
         default: begin
            add(ins, rnd(), rnd(), bt, mk(0,0,0,0,0,0,0,imm,0,0,0), "exec_mem");
            if (mw >= TMO) begin
               for (int i = 0; i < TMO; i++)
                  add(ins, rnd(), 1'b0, rnd(), mk(0,1,st,0,0,0,0,imm,0,0,0), "mem_wait");
               kind = 2;
               return;
            end
            for (int i = 0; i < mw; i++)
               add(ins, rnd(), 1'b0, rnd(), mk(0,1,st,0,0,0,0,imm,0,0,0), "mem_wait");
            if (st) begin
               add(ins, rnd(), 1'b1, rnd(), mk(0,1,1,0,1,0,0,imm,0,0,0), "mem_ack_st");
            end else begin
               add(ins, rnd(), 1'b1, rnd(), mk(0,1,0,0,0,0,0,imm,0,0,0), "mem_ack_ld");
               add(ins, rnd(), rnd(), rnd(), mk(0,0,0,0,1,1,0,imm,1,0,0), "wb");
            end
         end
      endcase
   endtask

   task automatic add_trap(input logic [31:0] ins, input int kind, input int n);
      for (int i = 0; i < n; i++)
         add(ins, rnd(), rnd(), rnd(),
             mk(0,0,0,0,0,0,0,0,0,kind == 1,kind == 2), "trap");
   endtask

   // Called just after a rising edge; each record occupies one clock cycle.
   task automatic play(input int limit);
      int n;
      n = 0;
      while (q.size() > 0 && (limit < 0 || n < limit)) begin
         cyc_t c;
         c = q.pop_front();
         instr_i    = c.ins;
         imem_ack_i = c.ia;
         dmem_ack_i = c.da;
         br_taken_i = c.bt;
         @(negedge clk_i);
         chk(c.tag, outs, c.exp);
         @(posedge clk_i);
         #1;
         n++;
      end
   endtask

   // Reset raised between edges: outputs must drop at once, stay low while
   // held, and FETCH starts in the cycle reset is released.
   task automatic do_reset();
      q.delete();
      rst_i      = 1'b1;
      imem_ack_i = 1'b0;
      dmem_ack_i = 1'b0;
      #1;
      chk("rst_async", outs, 16'h0000);
      @(negedge clk_i);
      chk("rst_hold", outs, 16'h0000);
      @(posedge clk_i);
      #1;
      chk("rst_edge", outs, 16'h0000);
      rst_i = 1'b0;
   endtask

   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                            input bit bt, input int trap_cycles);
      int kind;
      build(ins, fw, mw, bt, kind);
      if (kind != 0) add_trap(ins, kind, trap_cycles);
      play(-1);
      $display("instr %08h fw=%0d mw=%0d bt=%0d -> %s", ins, fw, mw, bt,
               kind == 0 ? "retired" : (kind == 1 ? "illegal trap" : "timeout trap"));
      if (kind != 0) do_reset();
   endtask

   initial begin
      logic [6:0]  ops [0:6];
      logic [31:0] ins;
      int          kind;
      ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
      ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
      ops[6] = 7'b1100111;

      @(posedge clk_i);
      #1;
      do_reset();

      // addi x1, x0, 5 with immediate fetch ack
      run_instr(32'h00500093, 0, 0, 1'b0, 0);
      // lw with data ack delayed three cycles
      run_instr(32'h0000a103, 0, 3, 1'b0, 0);
      // beq taken / not taken
      run_instr(32'h00208463, 1, 0, 1'b1, 0);
      run_instr(32'h00208463, 0, 0, 1'b0, 0);
      // sw, jal, jalr, R-type
      run_instr(32'h0020a023, 2, 1, 1'b0, 0);
      run_instr(32'h008000ef, 0, 0, 1'b1, 0);
      run_instr(32'h000080e7, 0, 0, 1'b0, 0);
      run_instr(32'h002081b3, 0, 0, 1'b0, 0);
      // illegal opcode: sticky for 100 cycles, then reset clears it
      run_instr(32'h0000007f, 0, 0, 1'b0, 100);
      // fetch ack never comes: trap after TMO fetch cycles
      run_instr(32'h00500093, TMO, 0, 1'b0, 5);
      // ack in the last allowed fetch cycle: no timeout
      run_instr(32'h00500093, TMO - 1, 0, 1'b0, 0);
      // data ack in the last allowed cycle, and one cycle too late
      run_instr(32'h0000a103, 0, TMO - 1, 1'b0, 0);
      run_instr(32'h0020a023, 0, TMO, 1'b0, 5);

      // reset mid-MEM: fetch, decode, exec plus four MEM cycles, then reset
      build(32'h0000a103, 0, 10, 1'b0, kind);
      play(7);
      $display("instr 0000a103 reset asserted during MEM");
      do_reset();
      run_instr(32'h00500093, 0, 0, 1'b0, 0);

      // randomized instruction stream
      for (int n = 0; n < 150; n++) begin
         int fw, mw, sel;
         sel = int'($urandom_range(0, 8));
         ins = $urandom();
         if (sel < 7) ins[6:0] = ops[sel];
         fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 1, TMO + 1))
                                          : int'($urandom_range(0, 3));
         mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 1, TMO + 1))
                                          : int'($urandom_range(0, 4));
         run_instr(ins, fw, mw, rnd(), int'($urandom_range(1, 4)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, the maximum cycles to wait for any memory acknowledge.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, the reset, which is asynchronous and active-high.
REQ-004 The block SHALL have port instr_i, input, 32, the instruction register contents, valid from DECODE onward.
REQ-005 The block SHALL have port br_taken_i, input, 1, the branch comparator result, sampled in EXEC.
REQ-006 The block SHALL have ports imem_ack_i and dmem_ack_i, input, 1 each, the instruction and data memory acknowledges.
REQ-007 The block SHALL have ports imem_req_o, dmem_req_o and dmem_we_o, output, 1 each, the memory request and data write-enable.
REQ-008 The block SHALL have ports ir_we_o, pc_we_o and rf_we_o, output, 1 each, the IR, PC and register-file write enables.
REQ-009 The block SHALL have port pc_sel_o, output, 2, selecting the next PC: 0=pc+4, 1=pc+imm, 2=ALU result (JALR).
REQ-010 The block SHALL have port imm_sel_o, output, 3, selecting the immediate format: 0=none, 1=I, 2=S, 3=B, 4=J.
REQ-011 The block SHALL have port wb_sel_o, output, 2, selecting the write-back source: 0=ALU, 1=memory, 2=pc+4.
REQ-012 The block SHALL have ports retire_o, illegal_o and timeout_o, output, 1 each: retire pulse, sticky illegal-opcode flag and sticky timeout flag.

Function
REQ-013 The block SHALL implement states FETCH, DECODE, EXEC, MEM, WB and TRAP, with outputs decoded from the state, instr_i[6:0] and the ack inputs.
REQ-014 In FETCH the block SHALL hold imem_req_o=1; on imem_ack_i=1 it SHALL assert ir_we_o=1 in the same cycle and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-015 DECODE SHALL last exactly one cycle; for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111 and 1100111 it SHALL go to EXEC, and for any other opcode it SHALL go to TRAP.
REQ-016 From DECODE through the end of the instruction, imm_sel_o SHALL be: 1 for 0000011, 0010011 and 1100111; 2 for 0100011; 3 for 1100011; 4 for 1101111; 0 otherwise.
REQ-017 For R-type (0110011) and I-ALU (0010011), EXEC SHALL assert rf_we_o=1, wb_sel_o=0 and pc_we_o=1 with pc_sel_o=0, then go to FETCH.
REQ-018 For branch (1100011), EXEC SHALL assert pc_we_o=1 with pc_sel_o=1 if br_taken_i=1, else pc_sel_o=0, keep rf_we_o=0, then go to FETCH.
REQ-019 For JAL (1101111) and JALR (1100111), EXEC SHALL assert rf_we_o=1, wb_sel_o=2 and pc_we_o=1 with pc_sel_o=1 (JAL) or 2 (JALR), then go to FETCH.
REQ-020 For load and store, EXEC SHALL go to MEM with no write enables asserted.
REQ-021 In MEM the block SHALL hold dmem_req_o=1, with dmem_we_o=1 for store and 0 for load, until dmem_ack_i=1.
REQ-022 On dmem_ack_i=1 in MEM, a store SHALL assert pc_we_o=1 with pc_sel_o=0 and go to FETCH, and a load SHALL go to WB.
REQ-023 WB SHALL last one cycle, asserting rf_we_o=1, wb_sel_o=1 and pc_we_o=1 with pc_sel_o=0, then go to FETCH.
REQ-024 retire_o SHALL equal pc_we_o, so it pulses exactly once per completed instruction.
REQ-025 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without ack; if it reaches TIMEOUT-1 without ack, the next state SHALL be TRAP with timeout_o set.
REQ-026 An ack arriving in the same cycle the counter reaches TIMEOUT-1 SHALL take priority, so no timeout occurs.
REQ-027 TRAP SHALL be absorbing: all request and enable outputs 0, illegal_o or timeout_o held at 1, exit only by reset.
REQ-028 Acks received outside FETCH (imem) or MEM (dmem) SHALL be ignored.
REQ-029 The typical cycle count SHALL be: ALU, branch and jump instructions 3 cycles plus fetch wait; store 4 plus waits; load 5 plus waits.

Reset
REQ-030 While rst_i=1, the state SHALL be FETCH, the counter 0 and all outputs 0 (including the sticky flags), regardless of the clock; this applies immediately, even mid-instruction.
REQ-031 After rst_i deasserts, imem_req_o SHALL be 1 from the first cycle.

Verification
REQ-032 The bench SHALL check: addi 0x00500093 with immediate ack -> ir_we_o, then DECODE with imm_sel_o=1, then EXEC with rf_we_o=1, pc_we_o=1, pc_sel_o=0 and retire_o=1.
REQ-033 The bench SHALL check: lw with dmem_ack_i delayed 3 cycles -> dmem_req_o high 4 cycles and dmem_we_o=0, then WB with rf_we_o=1 and wb_sel_o=1.
REQ-034 The bench SHALL check: beq with br_taken_i=1 -> pc_sel_o=1 and imm_sel_o=3; with br_taken_i=0 -> pc_sel_o=0; in both cases rf_we_o=0.
REQ-035 The bench SHALL check: opcode 0x7F -> TRAP with illegal_o=1 held for 100 cycles with no requests asserted; rst_i pulse -> illegal_o=0 and imem_req_o=1.
REQ-036 The bench SHALL check: imem_ack_i never asserted with TIMEOUT=16 -> TRAP with timeout_o=1 after 16 FETCH cycles; ack on cycle 16 instead -> no timeout.
REQ-037 The bench SHALL check: rst_i asserted mid-MEM between clock edges -> dmem_req_o=0 immediately, and FETCH resumes after release.
